// File: rtl/fb_reader.sv
// Frame scanner: sweeps the whole framebuffer in address order and streams
// each pixel out with its (x, y) coordinates through a 2-entry skid FIFO.
module fb_reader #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 4,
    parameter int COL_W  = 6
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    output logic [ADDR_W-1:0]       addr_out,
    input  logic [DATA_W-1:0]       q,
    output logic [DATA_W-1:0]       pix_data,
    output logic [COL_W-1:0]        pix_x,
    output logic [ADDR_W-COL_W-1:0] pix_y,
    output logic                    pix_valid,
    input  logic                    pix_ready,
    output logic                    pix_last,
    output logic                    busy,
    output logic                    frame_done
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic              inflight_q, inflight_d;
    logic [ADDR_W-1:0] infl_addr_q, infl_addr_d;
    logic              wr_ptr_q, wr_ptr_d;
    logic              rd_ptr_q, rd_ptr_d;
    logic [1:0]        count_q, count_d;

    logic              issue;
    logic              push;
    logic              pop;
    logic [1:0]        occupancy;
    logic [DATA_W-1:0] ent_data [2];
    logic [ADDR_W-1:0] ent_addr [2];
    logic [ADDR_W-1:0] head_addr;

    assign push      = inflight_q;
    assign pix_valid = (count_q != 2'd0);
    assign pop       = pix_valid & pix_ready;

    // Occupancy seen by a read issued now when its data lands: the head leaving
    // this cycle frees its slot in time, which keeps one beat per cycle flowing.
    assign occupancy = count_q + {1'b0, inflight_q} - {1'b0, pop};
    assign issue     = (state_q == SCAN) && (occupancy < 2'd2);

    always_comb begin
        state_d     = state_q;
        rd_addr_d   = rd_addr_q;
        inflight_d  = issue;
        infl_addr_d = issue ? rd_addr_q : infl_addr_q;
        wr_ptr_d    = push ? ~wr_ptr_q : wr_ptr_q;
        rd_ptr_d    = pop ? ~rd_ptr_q : rd_ptr_q;
        count_d     = count_q + {1'b0, push} - {1'b0, pop};
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = SCAN;
                    rd_addr_d = '0;
                end
            end
            SCAN: begin
                if (issue) begin
                    rd_addr_d = rd_addr_q + ADDR_W'(1);
                    if (rd_addr_q == LAST_ADDR) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (pop && pix_last) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            rd_addr_q   <= '0;
            inflight_q  <= 1'b0;
            infl_addr_q <= '0;
            wr_ptr_q    <= 1'b0;
            rd_ptr_q    <= 1'b0;
            count_q     <= 2'd0;
        end else begin
            state_q     <= state_d;
            rd_addr_q   <= rd_addr_d;
            inflight_q  <= inflight_d;
            infl_addr_q <= infl_addr_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
        end
    end

    // Entries are cleared on reset so the idle head reads as all zeros.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_entry
            logic [DATA_W-1:0] data_q, data_d;
            logic [ADDR_W-1:0] addr_q, addr_d;

            always_comb begin
                data_d = data_q;
                addr_d = addr_q;
                if (push && (wr_ptr_q == 1'(gi))) begin
                    data_d = q;
                    addr_d = infl_addr_q;
                end
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    data_q <= '0;
                    addr_q <= '0;
                end else begin
                    data_q <= data_d;
                    addr_q <= addr_d;
                end
            end

            assign ent_data[gi] = data_q;
            assign ent_addr[gi] = addr_q;
        end
    endgenerate

    assign head_addr  = ent_addr[rd_ptr_q];
    assign pix_data   = ent_data[rd_ptr_q];
    assign pix_x      = head_addr[COL_W-1:0];
    assign pix_y      = head_addr[ADDR_W-1:COL_W];
    assign pix_last   = pix_valid && (head_addr == LAST_ADDR);
    assign addr_out   = rd_addr_q;
    assign busy       = (state_q != IDLE);
    assign frame_done = (state_q == DONE);

endmodule

// File: tb/tb_fb_reader.sv
// Scoreboard bench for fb_reader: expected beat addresses are queued at each
// start, a negedge monitor pops and checks every transfer.
module tb_fb_reader;
    localparam int AW = 12;
    localparam int DW = 4;
    localparam int CW = 6;
    localparam int NBEATS = 1 << AW;
    localparam int LIMIT = 40000;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [AW-1:0] addr_out;
    logic [DW-1:0] q;
    logic [DW-1:0] pix_data;
    logic [CW-1:0] pix_x;
    logic [AW-CW-1:0] pix_y;
    logic          pix_valid;
    logic          pix_ready = 1'b0;
    logic          pix_last;
    logic          busy;
    logic          frame_done;

    int checks = 0;
    int failures = 0;
    int beats_seen = 0;
    logic [AW-1:0] exp_q[$];
    logic [DW-1:0] mem [NBEATS];

    fb_reader #(.ADDR_W(AW), .DATA_W(DW), .COL_W(CW)) dut (
        .clk(clk), .reset(reset), .start(start), .addr_out(addr_out), .q(q),
        .pix_data(pix_data), .pix_x(pix_x), .pix_y(pix_y), .pix_valid(pix_valid),
        .pix_ready(pix_ready), .pix_last(pix_last), .busy(busy), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    initial begin
        for (int a = 0; a < NBEATS; a++) mem[a] = DW'(a);
    end

    always @(posedge clk) q <= mem[addr_out];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    // Monitor: one comparison per transfer against the scoreboard head.
    always @(negedge clk) begin
        if (!reset && pix_valid && pix_ready) begin
            logic [AW-1:0] e;
            beats_seen++;
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_beat got_x=%0d got_y=%0d exp=none", pix_x, pix_y);
            end else begin
                e = exp_q.pop_front();
                chk($sformatf("beat_%0d", e),
                    {15'd0, pix_last, pix_data, pix_y, pix_x},
                    {15'd0, (e == AW'(NBEATS - 1)), e[DW-1:0], e[AW-1:CW], e[CW-1:0]});
            end
        end
    end

    task automatic do_start();
        @(posedge clk); #1;
        start = 1'b1;
        for (int a = 0; a < NBEATS; a++) exp_q.push_back(AW'(a));
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // n counts edges since the start edge; returns LIMIT on timeout.
    task automatic wait_done(input bit rnd, output int n);
        n = 0;
        while (n < LIMIT) begin
            @(negedge clk);
            if (frame_done) break;
            n++;
            if (rnd) begin
                @(posedge clk); #1;
                pix_ready = 1'($urandom_range(0, 1));
            end
        end
        if (n >= LIMIT) begin
            checks++;
            failures++;
            $display("FAIL frame_done_timeout got=none exp=pulse");
        end
    endtask

    task automatic frame_end_checks(input string tag, input int base);
        chk({tag, "_queue_empty"}, exp_q.size(), 0);
        chk({tag, "_beat_count"}, beats_seen - base, NBEATS);
        @(negedge clk);
        chk({tag, "_after_done"}, {frame_done, busy, pix_valid}, 3'b000);
    endtask

    initial begin
        int n;
        int base;
        int first_v;
        logic [AW-1:0] a_mid;

        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("reset_state", {pix_valid, pix_last, busy, frame_done, addr_out, pix_data, pix_x, pix_y},
            '0);

        // Full frame with pix_ready held high, checking latency and cadence.
        pix_ready = 1'b1;
        base = beats_seen;
        do_start();
        n = 0;
        first_v = -1;
        while (n < LIMIT) begin
            if (n > 0) @(negedge clk);
            if (pix_valid && first_v < 0) first_v = n;
            if (frame_done) break;
            n++;
            if (n == 1) @(negedge clk);
        end
        chk("first_valid_edge", first_v, 2);
        chk("done_edge", n, 4098);
        frame_end_checks("full", base);

        // Random backpressure.
        base = beats_seen;
        do_start();
        wait_done(1'b1, n);
        pix_ready = 1'b1;
        frame_end_checks("rand", base);

        // Stall for 20 cycles after the first beat appears.
        pix_ready = 1'b0;
        base = beats_seen;
        do_start();
        n = 0;
        while (!pix_valid && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("stall_first_valid", pix_valid, 1'b1);
        a_mid = '0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (i == 10) a_mid = addr_out;
            chk($sformatf("stall_hold_%0d", i), {pix_valid, pix_data, pix_x, pix_y}, {1'b1, 16'h0});
        end
        chk("stall_addr_le2", (addr_out <= AW'(2)), 1'b1);
        chk("stall_addr_stopped", addr_out, a_mid);
        @(posedge clk); #1;
        pix_ready = 1'b1;
        wait_done(1'b0, n);
        frame_end_checks("stall", base);

        // start pulsed mid-scan must not restart the frame.
        base = beats_seen;
        do_start();
        n = 0;
        while (beats_seen - base < 100 && n < 500) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        wait_done(1'b0, n);
        frame_end_checks("restart", base);

        // Reset mid-frame, then a clean frame must begin at address 0.
        base = beats_seen;
        do_start();
        n = 0;
        while (beats_seen - base < 1000 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk); #1;
        reset = 1'b1;
        exp_q.delete();
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("abort_state", {pix_valid, busy, addr_out}, '0);
        base = beats_seen;
        do_start();
        wait_done(1'b0, n);
        frame_end_checks("post_reset", base);

        // start together with reset in IDLE.
        @(posedge clk); #1;
        start = 1'b1;
        reset = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("start_reset_idle_%0d", i), {busy, pix_valid, addr_out}, '0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "timeout");
    end
endmodule
